// File: rtl/vga_pkg.sv
// Shared VGA display constants and the VRAM line-fetch state encoding.
// Imported by the arbiter and by anything else in the display path.
package vga_pkg;

   localparam int H_ACTIVE       = 640;
   localparam int V_ACTIVE       = 480;
   localparam int PIX_PER_WORD   = 8;
   localparam int WORDS_PER_LINE = H_ACTIVE / PIX_PER_WORD;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      FETCH = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: bursts one display line into the scan-out line buffer per
// line_start, interleaving CPU writes with a bounded wait while a fetch is running.
module vga_vram_arbiter #(
   parameter int WORDS_PER_LINE = vga_pkg::WORDS_PER_LINE,
   parameter int LINES          = vga_pkg::V_ACTIVE,
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 32,
   parameter int MAX_WAIT       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              line_start,
   input  logic [8:0]        line_num,
   output logic              fetch_busy,
   output logic              overrun,
   output logic              lb_we,
   output logic [6:0]        lb_waddr,
   output logic [DATA_W-1:0] lb_wdata,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   import vga_pkg::*;

   localparam int               IDX_W     = 7;
   localparam int               WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
   localparam logic [8:0]       LINES_N   = 9'(LINES);

   fetch_state_e      state;
   fetch_state_e      state_nxt;
   logic [ADDR_W-1:0] base;
   logic [IDX_W-1:0]  index;
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_pend;
   logic [WAIT_W-1:0] wait_cnt;

   logic              start_ok;
   logic              cpu_slot;
   logic              disp_rd;
   logic [ADDR_W-1:0] line_ext;
   logic [ADDR_W-1:0] base_calc;
   logic [ADDR_W-1:0] rd_addr;

   assign start_ok  = line_start && (line_num < LINES_N);
   // line_num*80 without a multiplier: 64n + 16n
   assign line_ext  = ADDR_W'(line_num);
   assign base_calc = (line_ext << 6) + (line_ext << 4);
   assign rd_addr   = base + ADDR_W'(index);

   // Outside FETCH the port is free, so the CPU is served at once; inside FETCH
   // only after it has been deferred MAX_WAIT cycles.
   assign cpu_slot = !reset && cpu_req && ((state != FETCH) || (wait_cnt == WAIT_MAX));
   assign disp_rd  = !reset && (state == FETCH) && !cpu_slot;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first so no path holds a stale value (no latches).
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start_ok) state_nxt = SETUP;
         SETUP:   state_nxt = FETCH;
         FETCH:   if (disp_rd && (index == LAST_IDX)) state_nxt = DRAIN;
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      cpu_ack    = 1'b0;
      if (cpu_slot) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         cpu_ack   = 1'b1;
      end else if (disp_rd) begin
         mem_en   = 1'b1;
         mem_addr = rd_addr;
      end
      fetch_busy = (state != IDLE);
      // Read data returns one cycle after issue; a read cut off by reset is dropped.
      lb_we      = rd_pend && !reset;
      lb_waddr   = lb_we ? rd_idx : '0;
      lb_wdata   = lb_we ? mem_rdata : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         base     <= '0;
         index    <= '0;
         rd_idx   <= '0;
         rd_pend  <= 1'b0;
         wait_cnt <= '0;
         overrun  <= 1'b0;
      end else begin
         if ((state == IDLE) && start_ok) base <= base_calc;

         if (state == SETUP)  index <= '0;
         else if (disp_rd)    index <= index + 1'b1;

         rd_pend <= disp_rd;
         if (disp_rd) rd_idx <= index;

         if (!cpu_req || cpu_slot)    wait_cnt <= '0;
         else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;

         if (line_start && (state != IDLE)) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Scoreboard bench for vga_vram_arbiter: a behavioural VRAM plus queues of expected
// port/line-buffer traffic, checked by an independent negedge monitor.
module tb_vga_vram_arbiter;

   localparam int WPL      = 80;
   localparam int LINES    = 480;
   localparam int MAX_WAIT = 4;

   typedef struct {
      int unsigned addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int unsigned idx;
      logic [31:0] data;
   } lb_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        line_start;
   logic [8:0]  line_num;
   logic        fetch_busy;
   logic        overrun;
   logic        lb_we;
   logic [6:0]  lb_waddr;
   logic [31:0] lb_wdata;
   logic        cpu_req;
   logic [15:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ack;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   int unsigned exp_rd[$];
   lb_t         exp_lb[$];
   wr_t         exp_cpu[$];

   logic [31:0] vram   [0:65535];
   bit          vram_v [0:65535];

   int en_q[$], lb_q[$], busy_q[$], ack_q[$];
   bit ack_prev;

   vga_vram_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .line_start (line_start),
      .line_num   (line_num),
      .fetch_busy (fetch_busy),
      .overrun    (overrun),
      .lb_we      (lb_we),
      .lb_waddr   (lb_waddr),
      .lb_wdata   (lb_wdata),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ack    (cpu_ack),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Unwritten VRAM words hold a fixed address-derived pattern.
   function automatic logic [31:0] vram_rd(input int unsigned a);
      return vram_v[a] ? vram[a] : (32'(a) * 32'h9E37_79B1) ^ 32'h5A17_C3E5;
   endfunction

   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         vram[mem_addr]   <= mem_wdata;
         vram_v[mem_addr] <= 1'b1;
      end
      mem_rdata <= (mem_en && !mem_we) ? vram_rd(32'(mem_addr)) : 32'h0BAD_F00D;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name, input logic [63:0] act);
      n_cmp++;
      n_err++;
      $display("FAIL %s: observed %0h where nothing was expected (t=%0t)", name, act, $time);
   endtask

   // Reference: a line fetch reads words n*80 .. n*80+79 in order and writes
   // them to line-buffer slots 0..79 in the same order.
   task automatic push_line(input int n);
      for (int i = 0; i < WPL; i++) begin
         exp_rd.push_back(n * WPL + i);
         exp_lb.push_back('{idx: i, data: vram_rd(n * WPL + i)});
      end
   endtask

   function automatic int q_first(input int q[$]);
      return (q.size() > 0) ? q[0] : -1;
   endfunction

   function automatic int q_last(input int q[$]);
      return (q.size() > 0) ? q[q.size() - 1] : -1;
   endfunction

   always @(negedge clk) begin
      wr_t e;
      lb_t l;
      if (!reset) begin
         if (mem_en && mem_we) begin
            if (exp_cpu.size() == 0) fail_now("unexpected_vram_write", 64'(mem_addr));
            else begin
               e = exp_cpu.pop_front();
               check("wr_addr", 64'(mem_addr), 64'(e.addr));
               check("wr_data", 64'(mem_wdata), 64'(e.data));
            end
         end else if (mem_en) begin
            if (exp_rd.size() == 0) fail_now("unexpected_vram_read", 64'(mem_addr));
            else check("rd_addr", 64'(mem_addr), 64'(exp_rd.pop_front()));
         end
         if (cpu_ack != (mem_en && mem_we)) fail_now("ack_vs_write", 64'(cpu_ack));
         if (lb_we) begin
            if (exp_lb.size() == 0) fail_now("unexpected_lb_we", 64'(lb_waddr));
            else begin
               l = exp_lb.pop_front();
               check("lb_waddr", 64'(lb_waddr), 64'(l.idx));
               check("lb_wdata", 64'(lb_wdata), 64'(l.data));
            end
         end
      end
   end

   // One directed fetch window; k counts cycles from the line_start cycle.
   task automatic fetch_window(input int n, input int len, input int cpu_at,
                               input logic [15:0] ca, input logic [31:0] cd,
                               input int second_at, input int second_n, input int reset_at);
      en_q.delete(); lb_q.delete(); busy_q.delete(); ack_q.delete();
      ack_prev = 1'b0;
      for (int k = 0; k < len; k++) begin
         @(posedge clk); #1;
         line_start = 1'b0;
         if (cpu_req && ack_prev) cpu_req = 1'b0;
         reset = (k == reset_at);
         if (reset_at >= 0 && k == reset_at + 1) begin
            exp_rd.delete(); exp_lb.delete(); exp_cpu.delete();
         end
         if (k == 0) begin
            line_start = 1'b1;
            line_num   = 9'(n);
            if (n < LINES) push_line(n);
         end
         if (k == second_at) begin
            line_start = 1'b1;
            line_num   = 9'(second_n);
         end
         if (k == cpu_at) begin
            cpu_req   = 1'b1;
            cpu_addr  = ca;
            cpu_wdata = cd;
            exp_cpu.push_back('{addr: ca, data: cd});
         end
         @(negedge clk);
         if (mem_en)     en_q.push_back(k);
         if (lb_we)      lb_q.push_back(k);
         if (fetch_busy) busy_q.push_back(k);
         if (cpu_ack)    ack_q.push_back(k);
         ack_prev = cpu_ack;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_fetch_busy"}, 64'(fetch_busy), 0);
      check({tag, "_overrun"},    64'(overrun),    0);
      check({tag, "_lb_we"},      64'(lb_we),      0);
      check({tag, "_lb_waddr"},   64'(lb_waddr),   0);
      check({tag, "_lb_wdata"},   64'(lb_wdata),   0);
      check({tag, "_cpu_ack"},    64'(cpu_ack),    0);
      check({tag, "_mem_en"},     64'(mem_en),     0);
      check({tag, "_mem_we"},     64'(mem_we),     0);
      check({tag, "_mem_addr"},   64'(mem_addr),   0);
      check({tag, "_mem_wdata"},  64'(mem_wdata),  0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; line_start = 1'b0; line_num = '0;
      cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      // Uncontended fetch of line 2.
      fetch_window(2, 90, -1, '0, '0, -1, 0, -1);
      check("l2_first_read",  64'(q_first(en_q)),   2);
      check("l2_last_read",   64'(q_last(en_q)),    81);
      check("l2_read_count",  64'(en_q.size()),     80);
      check("l2_first_lb",    64'(q_first(lb_q)),   3);
      check("l2_last_lb",     64'(q_last(lb_q)),    82);
      check("l2_lb_count",    64'(lb_q.size()),     80);
      check("l2_busy_first",  64'(q_first(busy_q)), 1);
      check("l2_busy_last",   64'(q_last(busy_q)),  82);
      check("l2_busy_count",  64'(busy_q.size()),   82);

      // CPU request raised with the 10th display read.
      fetch_window(5, 90, 11, 16'h1234, 32'hA5A5_A5A5, -1, 0, -1);
      check("cpu_ack_cycle",  64'(q_first(ack_q)),  15);
      check("cpu_ack_count",  64'(ack_q.size()),    1);
      check("cpu_port_cycles",64'(en_q.size()),     81);
      check("cpu_busy_last",  64'(q_last(busy_q)),  83);

      // CPU write while idle is granted in the same cycle.
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_addr = 16'h9700; cpu_wdata = 32'h1357_9BDF;
      exp_cpu.push_back('{addr: 32'h9700, data: 32'h1357_9BDF});
      @(negedge clk);
      check("idle_ack",   64'(cpu_ack),    1);
      check("idle_en",    64'(mem_en),     1);
      check("idle_we",    64'(mem_we),     1);
      check("idle_addr",  64'(mem_addr),   64'h9700);
      check("idle_data",  64'(mem_wdata),  64'h1357_9BDF);
      check("idle_busy",  64'(fetch_busy), 0);
      @(posedge clk); #1;
      cpu_req = 1'b0;

      // Second line_start mid-fetch is ignored but flagged.
      check("overrun_before", 64'(overrun), 0);
      fetch_window(7, 90, -1, '0, '0, 20, 9, -1);
      check("ovr_sticky",     64'(overrun),         1);
      check("ovr_read_count", 64'(en_q.size()),     80);
      check("ovr_busy_last",  64'(q_last(busy_q)),  82);

      // Reset while word 40 would be issued, then an out-of-range line_start.
      fetch_window(300, 44, -1, '0, '0, -1, 0, 42);
      check("rst_reads_before", 64'(en_q.size()), 40);
      check_all_zero("post_reset");
      fetch_window(480, 100, -1, '0, '0, -1, 0, -1);
      check("oor_no_reads", 64'(en_q.size()),   0);
      check("oor_no_lb",    64'(lb_q.size()),   0);
      check("oor_no_busy",  64'(busy_q.size()), 0);
      check("oor_overrun",  64'(overrun),       0);

      // Random fetches with random CPU traffic into the off-screen region.
      for (int r = 0; r < 14; r++) begin
         int  n;
         int  k;
         int  lat;
         bit  done;
         n    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(480, 511))
                                            : int'($urandom_range(0, LINES - 1));
         k    = 0;
         lat  = 0;
         done = 1'b0;
         ack_prev = 1'b0;
         while (!done && k < 400) begin
            @(posedge clk); #1;
            line_start = (k == 0);
            line_num   = 9'(n);
            if (k == 0 && n < LINES) push_line(n);
            if (cpu_req && ack_prev) cpu_req = 1'b0;
            if (!cpu_req && $urandom_range(0, 99) < 15) begin
               cpu_req   = 1'b1;
               cpu_addr  = 16'(38400 + $urandom_range(0, 20000));
               cpu_wdata = $urandom;
               exp_cpu.push_back('{addr: 32'(cpu_addr), data: cpu_wdata});
               lat = 0;
            end
            @(negedge clk);
            ack_prev = cpu_ack;
            if (cpu_req && !ack_prev) begin
               if (cpu_ack) check("rand_cpu_latency", 64'(lat <= MAX_WAIT), 1);
            end
            if (cpu_req) begin
               if (cpu_ack) check("rand_cpu_latency", 64'(lat <= MAX_WAIT), 1);
               else         lat++;
            end
            if (k >= 2 && !fetch_busy && !cpu_req) done = 1'b1;
            k++;
         end
         if (!done) fail_now("rand_timeout", 64'(k));
      end

      repeat (5) @(posedge clk);
      @(negedge clk);
      check("final_rd_queue",  64'(exp_rd.size()),  0);
      check("final_lb_queue",  64'(exp_lb.size()),  0);
      check("final_cpu_queue", 64'(exp_cpu.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
